// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide issue controller.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MADD    = 4'd5,
    MTHI    = 4'd6,
    MTLO    = 4'd7,
    MFHI    = 4'd8,
    MFLO    = 4'd9
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } md_state_t;

  localparam logic [1:0] RD_NONE = 2'd0;
  localparam logic [1:0] RD_HI   = 2'd1;
  localparam logic [1:0] RD_LO   = 2'd2;

  // Ops that start a multi-cycle operation in the unit.
  function automatic logic md_starts_unit(input md_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) ||
           (op == DIVU) || (op == MADD);
  endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// Issue controller between the E stage and the multiply/divide unit.
// Optional macro MD_MADD_EN enables issuing MADD; otherwise MADD is a non-md op.
//
// state   | meaning
// IDLE    | unit free; md ops are accepted in the cycle they appear
// WAIT    | unit started; md ops stall until busy drops or the wait times out
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_E,
  input  logic       flush_E,
  input  md_op_t     op_E,
  input  logic       busy,
  output logic       mult,
  output logic       multu,
  output logic       div,
  output logic       divu,
  output logic       madd,
  output logic       mthi,
  output logic       mtlo,
  output logic       stall,
  output logic [1:0] rd_sel,
  output logic       timeout_err
);

`ifdef MD_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif

  localparam logic [4:0] CNT_LAST = 5'(MAX_WAIT - 1);

  md_state_t  state, state_next;
  logic [4:0] cnt, cnt_next;
  logic       timeout_q, timeout_set;
  logic       is_md, live, accept;

  // Unknown encodings and a disabled MADD behave like ordinary non-md instructions.
  assign is_md  = (op_E != MD_NONE) && (op_E <= MFLO) && !((op_E == MADD) && !MADD_EN);
  assign live   = valid_E && !flush_E && !reset && is_md;
  assign accept = live && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 5'd0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      timeout_q <= timeout_q || timeout_set;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    timeout_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && md_starts_unit(op_E)) begin
          state_next = ST_WAIT;
          cnt_next   = 5'd0;
        end
      end
      ST_WAIT: begin
        if (!busy) begin
          state_next = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_set = 1'b1;
          state_next  = ST_IDLE;
        end else begin
          cnt_next = cnt + 5'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mult   = 1'b0;
    multu  = 1'b0;
    div    = 1'b0;
    divu   = 1'b0;
    madd   = 1'b0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    rd_sel = RD_NONE;
    if (accept) begin
      case (op_E)
        MULT:  mult  = 1'b1;
        MULTU: multu = 1'b1;
        DIV:   div   = 1'b1;
        DIVU:  divu  = 1'b1;
`ifdef MD_MADD_EN
        MADD:  madd  = 1'b1;
`endif
        MTHI:  mthi  = 1'b1;
        MTLO:  mtlo  = 1'b1;
        MFHI:  rd_sel = RD_HI;
        MFLO:  rd_sel = RD_LO;
        default: ;
      endcase
    end
  end

  assign stall       = live && (state == ST_WAIT);
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_md_issue_ctrl;
  import md_pkg::*;

  localparam int MW = 15;

`ifdef MD_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, valid_E, flush_E, busy;
  md_op_t op_E;
  logic mult, multu, div, divu, madd, mthi, mtlo, stall, timeout_err;
  logic [1:0] rd_sel;

  int checks = 0;
  int failures = 0;

  // Model: is a unit operation outstanding, how many busy cycles it has waited, sticky error.
  bit m_wait = 1'b0;
  int m_waited = 0;
  bit m_to = 1'b0;

  md_issue_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .flush_E(flush_E), .op_E(op_E),
    .busy(busy), .mult(mult), .multu(multu), .div(div), .divu(divu), .madd(madd),
    .mthi(mthi), .mtlo(mtlo), .stall(stall), .rd_sel(rd_sel), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit md_op(input int op);
    return (op >= 1) && (op <= 9) && !((op == 5) && !MADD_ON);
  endfunction

  always @(negedge clk) begin : cmp
    int op;
    bit live, acc;
    logic [6:0] exp_strb;
    logic [1:0] exp_rd;
    op = int'(op_E);
    live = !reset && valid_E && !flush_E && md_op(op);
    acc = live && !m_wait;
    exp_strb = (acc && op >= 1 && op <= 7) ? 7'(1 << (7 - op)) : 7'd0;
    exp_rd = (acc && op == 8) ? 2'd1 : (acc && op == 9) ? 2'd2 : 2'd0;
    chk("strobes", {1'b0, mult, multu, div, divu, madd, mthi, mtlo}, {1'b0, exp_strb});
    chk("rd_sel", {6'd0, rd_sel}, {6'd0, exp_rd});
    chk("stall", {7'd0, stall}, {7'd0, live && m_wait});
    chk("timeout_err", {7'd0, timeout_err}, {7'd0, m_to});
    if (reset) begin
      m_wait = 0; m_waited = 0; m_to = 0;
    end else if (!m_wait) begin
      if (acc && op >= 1 && op <= 5) begin
        m_wait = 1; m_waited = 0;
      end
    end else if (!busy) begin
      m_wait = 0;
    end else begin
      m_waited++;
      if (m_waited == MW) begin
        m_to = 1; m_wait = 0;
      end
    end
  end

  task automatic cyc(input bit v, input bit f, input md_op_t op, input bit b, input bit r);
    @(posedge clk);
    #1;
    valid_E = v; flush_E = f; op_E = op; busy = b; reset = r;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int hold;
    reset = 1; valid_E = 0; flush_E = 0; op_E = MD_NONE; busy = 0;
    cyc(0, 0, MD_NONE, 0, 1);
    cyc(1, 0, MFHI, 0, 1);
    chk("lit_reset_stall", {7'd0, stall}, 8'd0);
    chk("lit_reset_rd", {6'd0, rd_sel}, 8'd0);
    chk("lit_reset_to", {7'd0, timeout_err}, 8'd0);

    // First accept right after reset deasserts; unit finishes immediately.
    cyc(1, 0, MULT, 0, 0);
    chk("lit_first_mult", {7'd0, mult}, 8'd1);
    cyc(0, 0, MD_NONE, 0, 0);

    // MULT, busy for five cycles then low: MFHI stalls through cycle 6, reads in 7.
    cyc(1, 0, MULT, 0, 0);
    chk("lit_mult_c0", {7'd0, mult}, 8'd1);
    for (int i = 1; i <= 5; i++) cyc(1, 0, MFHI, 1, 0);
    chk("lit_mult_nostrobe", {7'd0, mult}, 8'd0);
    chk("lit_mfhi_stall", {7'd0, stall}, 8'd1);
    cyc(1, 0, MFHI, 0, 0);
    chk("lit_mfhi_stall_c6", {7'd0, stall}, 8'd1);
    cyc(1, 0, MFHI, 0, 0);
    chk("lit_mfhi_rd_c7", {6'd0, rd_sel}, 8'd1);
    chk("lit_mfhi_nostall_c7", {7'd0, stall}, 8'd0);

    // Timeout after MW busy WAIT cycles.
    cyc(1, 0, DIVU, 0, 0);
    chk("lit_divu", {7'd0, divu}, 8'd1);
    for (int i = 1; i <= MW; i++) cyc(0, 0, MD_NONE, 1, 0);
    chk("lit_to_before", {7'd0, timeout_err}, 8'd0);
    cyc(1, 0, MULT, 1, 0);
    chk("lit_to_set", {7'd0, timeout_err}, 8'd1);
    chk("lit_mult_after_to", {7'd0, mult}, 8'd1);

    // Reset in the third WAIT cycle with a stalled MFLO.
    cyc(1, 0, MFLO, 1, 0);
    cyc(1, 0, MFLO, 1, 0);
    chk("lit_mflo_stall", {7'd0, stall}, 8'd1);
    cyc(1, 0, MFLO, 1, 1);
    chk("lit_rst_stall", {7'd0, stall}, 8'd0);
    cyc(1, 0, MFLO, 1, 0);
    chk("lit_rst_to_clr", {7'd0, timeout_err}, 8'd0);
    chk("lit_rst_mflo_rd", {6'd0, rd_sel}, 8'd2);

    // MTHI then MFHI.
    cyc(1, 0, MTHI, 0, 0);
    chk("lit_mthi", {7'd0, mthi}, 8'd1);
    cyc(1, 0, MFHI, 0, 0);
    chk("lit_mthi_mfhi_rd", {6'd0, rd_sel}, 8'd1);
    chk("lit_mthi_mfhi_stall", {7'd0, stall}, 8'd0);

    // Flushed DIV: no strobe, no WAIT.
    cyc(1, 1, DIV, 0, 0);
    chk("lit_flush_div", {7'd0, div}, 8'd0);
    cyc(1, 0, MD_NONE, 1, 0);
    chk("lit_add_nostall", {7'd0, stall}, 8'd0);
    cyc(1, 0, MULT, 1, 0);
    chk("lit_idle_after_flush", {7'd0, mult}, 8'd1);
    cyc(1, 0, MD_NONE, 1, 0);
    chk("lit_add_in_wait", {7'd0, stall}, 8'd0);
    cyc(0, 0, MD_NONE, 0, 0);

    // MADD depends on configuration.
    cyc(1, 0, MADD, 0, 0);
    chk("lit_madd", {7'd0, madd}, {7'd0, MADD_ON});
    cyc(1, 0, MFHI, 1, 0);
    chk("lit_madd_stall", {7'd0, stall}, {7'd0, MADD_ON});
    cyc(0, 0, MD_NONE, 0, 0);
    cyc(0, 0, MD_NONE, 0, 0);

    // Randomized traffic; long busy bursts exercise the timeout path.
    hold = 0;
    for (int n = 0; n < 4000; n++) begin
      bit b;
      if (hold > 0) begin
        b = 1; hold--;
      end else begin
        if ($urandom_range(0, 39) == 0) hold = $urandom_range(10, 25);
        b = ($urandom_range(0, 3) != 0);
      end
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
          md_op_t'($urandom_range(0, 9)), b, $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
